// File: rtl/pipe_arith_unit_if.sv
// Operand/result handshake bundle for pipe_arith_unit.
// The master drives operands and out_ready. The slave (the unit) drives in_ready and the result side.
interface pipe_arith_unit_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [3:0]       flags;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, flags
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, flags
    );
endinterface

// File: rtl/pipe_arith_unit.sv
// Two-stage pipelined add/sub/saturate/abs-diff/accumulate unit with registered {N,Z,C,V} flags.
// Stage 1 captures the raw WIDTH+1 bit sum/difference. Stage 2 applies saturation or abs and forms the flags.
module pipe_arith_unit #(
    parameter int WIDTH   = 8,
    parameter bit ACC_SAT = 1'b1
) (
    input logic              clk,
    input logic              rst_n,
    pipe_arith_unit_if.slave bus
);
    typedef enum logic [2:0] {
        OP_ADD     = 3'b000,
        OP_SUB     = 3'b001,
        OP_ADD_SAT = 3'b010,
        OP_SUB_SAT = 3'b011,
        OP_ABSDIFF = 3'b100,
        OP_ACC     = 3'b101,
        OP_ACC_CLR = 3'b110,
        OP_RSVD    = 3'b111
    } op_e;

    localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

    logic             s1_valid;
    logic [WIDTH:0]   s1_raw;
    op_e              s1_op;
    logic             s1_v;
    logic [WIDTH-1:0] acc;

    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic [3:0]       flags_q;

    logic             adv;
    logic             accept;
    op_e              op_in;
    logic [WIDTH:0]   raw_d;
    logic             v_d;
    logic [WIDTH-1:0] acc_d;
    logic [WIDTH-1:0] r2;
    logic             c2;

    assign adv          = bus.out_ready || !out_valid_q;
    assign bus.in_ready = adv || !s1_valid;
    assign accept       = bus.in_valid && bus.in_ready;
    assign op_in        = op_e'(bus.op);

    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.flags     = flags_q;

    // The accumulator is resolved at acceptance, so back-to-back ACC beats see the previous total.
    always_comb begin
        raw_d = {1'b0, bus.a} + {1'b0, bus.b};
        v_d   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (raw_d[WIDTH-1] != bus.a[WIDTH-1]);
        acc_d = acc;
        case (op_in)
            OP_SUB, OP_SUB_SAT: begin
                raw_d = {1'b0, bus.a} + {1'b0, ~bus.b} + ONE;
                v_d   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (raw_d[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_ABSDIFF: begin
                raw_d = {1'b0, bus.a} + {1'b0, ~bus.b} + ONE;
                v_d   = 1'b0;
            end
            OP_ACC: begin
                raw_d = {1'b0, acc} + {1'b0, bus.a};
                v_d   = 1'b0;
                acc_d = (ACC_SAT && raw_d[WIDTH]) ? '1 : raw_d[WIDTH-1:0];
            end
            OP_ACC_CLR: begin
                raw_d = {1'b0, bus.a};
                v_d   = 1'b0;
                acc_d = bus.a;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_raw   <= '0;
            s1_op    <= OP_ADD;
            s1_v     <= 1'b0;
            acc      <= '0;
        end else begin
            if (bus.in_ready)
                s1_valid <= bus.in_valid;
            if (accept) begin
                s1_raw <= raw_d;
                s1_op  <= op_in;
                s1_v   <= v_d;
                acc    <= acc_d;
            end
        end
    end

    // For the SUB family, raw carry out of a+~b+1 is the no-borrow flag (a >= b).
    always_comb begin
        c2 = s1_raw[WIDTH];
        r2 = s1_raw[WIDTH-1:0];
        case (s1_op)
            OP_ADD_SAT: if (c2) r2 = '1;
            OP_SUB_SAT: if (!c2) r2 = '0;
            OP_ABSDIFF: if (!c2) r2 = '0 - s1_raw[WIDTH-1:0];
            OP_ACC:     if (ACC_SAT && c2) r2 = '1;
            OP_ACC_CLR: c2 = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
        end else if (adv) begin
            out_valid_q <= s1_valid;
            if (s1_valid) begin
                result_q <= r2;
                flags_q  <= {r2[WIDTH-1], r2 == '0, c2, s1_v};
            end
        end
    end
endmodule

// File: tb/tb_pipe_arith_unit.sv
// Self-checking bench for pipe_arith_unit at WIDTH=4.
// Uses a saturating-ACC instance and a wrapping-ACC instance, checked against an integer reference model.
module tb_pipe_arith_unit;
    localparam int W    = 4;
    localparam int MAXV = 1 << W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   acc_s = 0;
    int   acc_w = 0;

    always #5 clk = ~clk;

    pipe_arith_unit_if #(.WIDTH(W)) bs ();
    pipe_arith_unit_if #(.WIDTH(W)) bw ();

    pipe_arith_unit #(.WIDTH(W), .ACC_SAT(1'b1)) dut_s (.clk(clk), .rst_n(rst_n), .bus(bs));
    pipe_arith_unit #(.WIDTH(W), .ACC_SAT(1'b0)) dut_w (.clk(clk), .rst_n(rst_n), .bus(bw));

    // Reference model: returns {result, N, Z, C, V}.
    function automatic logic [W+3:0] ref_op(input logic [2:0] op, input int ua, input int ub,
                                            input bit sat, inout int acc);
        int sa, sb, s, r;
        bit c, v;
        logic [W-1:0] rr;
        sa = (ua >= MAXV / 2) ? ua - MAXV : ua;
        sb = (ub >= MAXV / 2) ? ub - MAXV : ub;
        case (op)
            3'd1, 3'd3, 3'd4: begin
                c = (ua >= ub);
                v = ((sa - sb) > MAXV / 2 - 1) || ((sa - sb) < -(MAXV / 2));
                if (op == 3'd1)      r = (ua - ub + MAXV) % MAXV;
                else if (op == 3'd3) r = c ? ua - ub : 0;
                else begin
                    r = c ? ua - ub : ub - ua;
                    v = 1'b0;
                end
            end
            3'd5: begin
                s = acc + ua;
                c = (s >= MAXV);
                acc = c ? (sat ? MAXV - 1 : s - MAXV) : s;
                r = acc;
                v = 1'b0;
            end
            3'd6: begin
                acc = ua;
                r = ua;
                c = 1'b0;
                v = 1'b0;
            end
            default: begin
                s = ua + ub;
                c = (s >= MAXV);
                v = ((sa + sb) > MAXV / 2 - 1) || ((sa + sb) < -(MAXV / 2));
                r = (op == 3'd2 && c) ? MAXV - 1 : s % MAXV;
            end
        endcase
        rr = r[W-1:0];
        return {rr, r >= MAXV / 2, r == 0, c, v};
    endfunction

    task automatic send_beat(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        bs.in_valid = 1'b1;
        bs.op = op;
        bs.a = a;
        bs.b = b;
        @(negedge clk);
        bs.in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (bs.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bs.out_valid); end
        n_checks++; if (bs.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bs.in_ready); end
        n_checks++; if (bs.result !== 4'h0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", bs.result); end
        n_checks++; if (bs.flags !== 4'h0) begin n_fail++; $display("FAIL reset_flags: got %b expected 0000", bs.flags); end
        @(negedge clk);
        rst_n = 1'b1;
        acc_s = 0;
        acc_w = 0;
    endtask

    task automatic test_directed;
        logic [2:0] ops [6] = '{3'd1, 3'd3, 3'd1, 3'd4, 3'd0, 3'd2};
        logic [3:0] as  [6] = '{4'b0101, 4'b0101, 4'b1111, 4'b0001, 4'b1111, 4'b1111};
        logic [3:0] bsv [6] = '{4'b1100, 4'b1100, 4'b1111, 4'b0111, 4'b1111, 4'b1111};
        logic [3:0] er  [6] = '{4'b1001, 4'b0000, 4'b0000, 4'b0110, 4'b1110, 4'b1111};
        logic [3:0] ef  [6] = '{4'b1001, 4'b0101, 4'b0110, 4'b0000, 4'b1010, 4'b1010};
        for (int i = 0; i < 6; i++) begin
            send_beat(ops[i], as[i], bsv[i]);
            n_checks++; if (bs.out_valid !== 1'b0) begin n_fail++; $display("FAIL directed_early[%0d]: out_valid %b expected 0", i, bs.out_valid); end
            @(negedge clk);
            n_checks++; if (bs.out_valid !== 1'b1) begin n_fail++; $display("FAIL directed_latency[%0d]: out_valid %b expected 1", i, bs.out_valid); end
            n_checks++; if ({bs.result, bs.flags} !== {er[i], ef[i]})
                begin n_fail++; $display("FAIL directed[%0d] op=%0d: got r=%b f=%b expected r=%b f=%b", i, ops[i], bs.result, bs.flags, er[i], ef[i]); end
        end
        @(negedge clk);
    endtask

    task automatic test_acc;
        logic [2:0] ops [3] = '{3'd6, 3'd5, 3'd5};
        logic [3:0] as  [3] = '{4'd3, 4'd7, 4'd9};
        logic [7:0] exp_s [3] = '{{4'd3, 4'b0000}, {4'd10, 4'b1000}, {4'd15, 4'b1010}};
        logic [7:0] exp_w [3] = '{{4'd3, 4'b0000}, {4'd10, 4'b1000}, {4'd3, 4'b0010}};
        logic [7:0] got_s [$];
        logic [7:0] got_w [$];
        fork
            begin
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    bs.in_valid = 1'b1; bs.op = ops[i]; bs.a = as[i]; bs.b = 4'($urandom);
                    bw.in_valid = 1'b1; bw.op = ops[i]; bw.a = as[i]; bw.b = 4'($urandom);
                end
                @(negedge clk);
                bs.in_valid = 1'b0;
                bw.in_valid = 1'b0;
            end
            begin
                for (int cyc = 0; cyc < 12 && (got_s.size() < 3 || got_w.size() < 3); cyc++) begin
                    @(negedge clk);
                    #1;
                    if (bs.out_valid) got_s.push_back({bs.result, bs.flags});
                    if (bw.out_valid) got_w.push_back({bw.result, bw.flags});
                end
            end
        join
        n_checks++; if (got_s.size() != 3) begin n_fail++; $display("FAIL acc_sat_count: got %0d expected 3", got_s.size()); end
        n_checks++; if (got_w.size() != 3) begin n_fail++; $display("FAIL acc_wrap_count: got %0d expected 3", got_w.size()); end
        for (int i = 0; i < got_s.size() && i < 3; i++) begin
            n_checks++; if (got_s[i] !== exp_s[i]) begin n_fail++; $display("FAIL acc_sat[%0d]: got %h expected %h", i, got_s[i], exp_s[i]); end
        end
        for (int i = 0; i < got_w.size() && i < 3; i++) begin
            n_checks++; if (got_w[i] !== exp_w[i]) begin n_fail++; $display("FAIL acc_wrap[%0d]: got %h expected %h", i, got_w[i], exp_w[i]); end
        end
        acc_s = 15;
        acc_w = 3;
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        logic [W+3:0] exp_q [$];
        logic [W+3:0] held, e;
        logic [2:0]   ops [4];
        logic [3:0]   as [4];
        logic [3:0]   bv [4];
        int sent = 0;
        int got = 0;
        for (int i = 0; i < 4; i++) begin
            ops[i] = 3'($urandom_range(6, 0));
            as[i] = 4'($urandom);
            bv[i] = 4'($urandom);
        end
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            bs.out_ready = (cyc >= 8);
            if (sent < 4) begin
                bs.in_valid = 1'b1; bs.op = ops[sent]; bs.a = as[sent]; bs.b = bv[sent];
            end else bs.in_valid = 1'b0;
            #1;
            if (cyc == 2) held = {bs.result, bs.flags};
            if (cyc == 6) begin
                n_checks++; if (sent != 2) begin n_fail++; $display("FAIL bp_accepted: got %0d expected 2", sent); end
                n_checks++; if (bs.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b expected 0", bs.in_ready); end
            end
            if (cyc >= 3 && cyc <= 7) begin
                n_checks++; if (bs.out_valid !== 1'b1 || {bs.result, bs.flags} !== held)
                    begin n_fail++; $display("FAIL bp_stable c%0d: got v=%b %h expected v=1 %h", cyc, bs.out_valid, {bs.result, bs.flags}, held); end
            end
            if (bs.out_valid && bs.out_ready) begin
                got++;
                n_checks++;
                if (exp_q.size() == 0) begin n_fail++; $display("FAIL bp_dup: got %h expected no beat", {bs.result, bs.flags}); end
                else begin
                    e = exp_q.pop_front();
                    if ({bs.result, bs.flags} !== e) begin n_fail++; $display("FAIL bp_order[%0d]: got %h expected %h", got - 1, {bs.result, bs.flags}, e); end
                end
            end
            if (bs.in_valid && bs.in_ready) begin
                exp_q.push_back(ref_op(bs.op, int'(bs.a), int'(bs.b), 1'b1, acc_s));
                sent++;
            end
            if (sent == 4 && got == 4 && cyc > 8) break;
        end
        bs.in_valid = 1'b0;
        bs.out_ready = 1'b1;
        n_checks++; if (got != 4) begin n_fail++; $display("FAIL bp_count: got %0d expected 4", got); end
    endtask

    task automatic test_random;
        logic [W+3:0] exp_q [$];
        logic [W+3:0] prev, e;
        bit prev_stall = 1'b0;
        for (int cyc = 0; cyc < 340; cyc++) begin
            @(negedge clk);
            if (cyc < 300) begin
                bs.in_valid = ($urandom_range(9, 0) < 7);
                bs.out_ready = ($urandom_range(9, 0) < 7);
                bs.op = 3'($urandom_range(7, 0));
                bs.a = 4'($urandom);
                bs.b = 4'($urandom);
            end else begin
                bs.in_valid = 1'b0;
                bs.out_ready = 1'b1;
            end
            #1;
            if (prev_stall) begin
                n_checks++; if (bs.out_valid !== 1'b1 || {bs.result, bs.flags} !== prev)
                    begin n_fail++; $display("FAIL rnd_hold c%0d: got v=%b %h expected v=1 %h", cyc, bs.out_valid, {bs.result, bs.flags}, prev); end
            end
            if (exp_q.size() < 2) begin
                n_checks++; if (bs.in_ready !== 1'b1) begin n_fail++; $display("FAIL rnd_ready c%0d: got %b expected 1 with %0d in flight", cyc, bs.in_ready, exp_q.size()); end
            end
            if (bs.out_valid && bs.out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin n_fail++; $display("FAIL rnd_extra c%0d: got %h expected no beat", cyc, {bs.result, bs.flags}); end
                else begin
                    e = exp_q.pop_front();
                    if ({bs.result, bs.flags} !== e) begin n_fail++; $display("FAIL rnd_data c%0d: got %h expected %h", cyc, {bs.result, bs.flags}, e); end
                end
            end
            if (bs.in_valid && bs.in_ready)
                exp_q.push_back(ref_op(bs.op, int'(bs.a), int'(bs.b), 1'b1, acc_s));
            prev_stall = bs.out_valid && !bs.out_ready;
            prev = {bs.result, bs.flags};
        end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rnd_drain: got %0d left expected 0", exp_q.size()); end
    endtask

    task automatic test_reset_midflight;
        logic [W+3:0] e;
        bs.out_ready = 1'b0;
        @(negedge clk);
        bs.in_valid = 1'b1; bs.op = 3'd6; bs.a = 4'd9; bs.b = 4'd0;
        @(negedge clk);
        bs.op = 3'd5; bs.a = 4'd2;
        @(negedge clk);
        bs.in_valid = 1'b0;
        n_checks++; if (bs.out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_inflight: out_valid %b expected 1", bs.out_valid); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (bs.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_out_valid: got %b expected 0", bs.out_valid); end
        n_checks++; if ({bs.result, bs.flags} !== 8'h00) begin n_fail++; $display("FAIL mid_result: got %h expected 00", {bs.result, bs.flags}); end
        n_checks++; if (bs.in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_in_ready: got %b expected 1", bs.in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        acc_s = 0;
        bs.out_ready = 1'b1;
        e = ref_op(3'd5, 5, 0, 1'b1, acc_s);
        send_beat(3'd5, 4'd5, 4'd0);
        n_checks++; if (bs.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale: out_valid %b expected 0", bs.out_valid); end
        @(negedge clk);
        n_checks++; if (bs.out_valid !== 1'b1 || {bs.result, bs.flags} !== e)
            begin n_fail++; $display("FAIL mid_first: got v=%b %h expected v=1 %h", bs.out_valid, {bs.result, bs.flags}, e); end
        @(negedge clk);
    endtask

    initial begin
        bs.in_valid = 1'b0; bs.op = 3'd0; bs.a = '0; bs.b = '0; bs.out_ready = 1'b1;
        bw.in_valid = 1'b0; bw.op = 3'd0; bw.a = '0; bw.b = '0; bw.out_ready = 1'b1;
        test_reset;
        test_directed;
        test_acc;
        test_backpressure;
        test_random;
        test_reset_midflight;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end
endmodule
